// File: rtl/gemm_loop_ctrl.sv
// Loop and address sequencer for a single-MAC GEMM: walks m (outer), n, k (inner) and drives A/B read
// addresses, C write address/enable and MAC strobes aligned to the 1-cycle SRAM read latency.
module gemm_loop_ctrl #(
  parameter int AddrWidth      = 10,
  parameter int SRAMAddrWidthA = 10,
  parameter int SRAMAddrWidthB = 10,
  parameter int SRAMAddrWidthC = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [AddrWidth-1:0]      M_size_i,
  input  logic [AddrWidth-1:0]      K_size_i,
  input  logic [AddrWidth-1:0]      N_size_i,
  output logic [SRAMAddrWidthA-1:0] sram_a_addr_o,
  output logic [SRAMAddrWidthB-1:0] sram_b_addr_o,
  output logic [SRAMAddrWidthC-1:0] sram_c_addr_o,
  output logic                      sram_c_we_o,
  output logic                      mac_valid_o,
  output logic                      mac_clear_o,
  output logic                      mac_last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]                state_q;
  logic                      drain_cnt_q;
  logic [AddrWidth-1:0]      m_size_q, k_size_q, n_size_q;
  logic [AddrWidth-1:0]      m_q, n_q, k_q;
  logic [AddrWidth-1:0]      n_nxt;
  logic [SRAMAddrWidthA-1:0] a_ptr_q, a_base_q, a_base_nxt;
  logic [SRAMAddrWidthB-1:0] b_ptr_q;
  logic [SRAMAddrWidthC-1:0] c_ptr_q, c_addr_d1_q, c_addr_d2_q;
  logic                      valid_d1_q, clear_d1_q, last_d1_q, we_d2_q;
  logic                      run, k_last, n_last, m_last, size_zero;

  assign run        = (state_q == StRun);
  assign k_last     = (k_q == k_size_q - AddrWidth'(1));
  assign n_last     = (n_q == n_size_q - AddrWidth'(1));
  assign m_last     = (m_q == m_size_q - AddrWidth'(1));
  assign size_zero  = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  assign n_nxt      = n_last ? '0 : n_q + AddrWidth'(1);
  assign a_base_nxt = a_base_q + SRAMAddrWidthA'(k_size_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      drain_cnt_q <= 1'b0;
      m_size_q    <= '0;
      k_size_q    <= '0;
      n_size_q    <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      a_ptr_q     <= '0;
      a_base_q    <= '0;
      b_ptr_q     <= '0;
      c_ptr_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            m_size_q <= M_size_i;
            k_size_q <= K_size_i;
            n_size_q <= N_size_i;
            m_q      <= '0;
            n_q      <= '0;
            k_q      <= '0;
            a_ptr_q  <= '0;
            a_base_q <= '0;
            b_ptr_q  <= '0;
            c_ptr_q  <= '0;
            state_q  <= size_zero ? StDone : StRun;
          end
        end
        StRun: begin
          if (k_last) begin
            // End of a dot product: B rewinds to the next column, A to the row base.
            k_q     <= '0;
            n_q     <= n_nxt;
            b_ptr_q <= SRAMAddrWidthB'(n_nxt);
            c_ptr_q <= c_ptr_q + SRAMAddrWidthC'(1);
            if (n_last) begin
              m_q      <= m_q + AddrWidth'(1);
              a_base_q <= a_base_nxt;
              a_ptr_q  <= a_base_nxt;
            end else begin
              a_ptr_q  <= a_base_q;
            end
          end else begin
            k_q     <= k_q + AddrWidth'(1);
            a_ptr_q <= a_ptr_q + SRAMAddrWidthA'(1);
            b_ptr_q <= b_ptr_q + SRAMAddrWidthB'(n_size_q);
          end
          if (k_last && n_last && m_last) begin
            state_q     <= StDrain;
            drain_cnt_q <= 1'b0;
          end
        end
        StDrain: begin
          drain_cnt_q <= 1'b1;
          if (drain_cnt_q) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Strobes trail the address issue by the SRAM read latency; the C write trails by one more.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_d1_q  <= 1'b0;
      clear_d1_q  <= 1'b0;
      last_d1_q   <= 1'b0;
      we_d2_q     <= 1'b0;
      c_addr_d1_q <= '0;
      c_addr_d2_q <= '0;
    end else begin
      valid_d1_q  <= run;
      clear_d1_q  <= run && (k_q == '0);
      last_d1_q   <= run && k_last;
      c_addr_d1_q <= c_ptr_q;
      we_d2_q     <= valid_d1_q && last_d1_q;
      c_addr_d2_q <= c_addr_d1_q;
    end
  end

  assign sram_a_addr_o = run ? a_ptr_q : '0;
  assign sram_b_addr_o = run ? b_ptr_q : '0;
  assign sram_c_addr_o = we_d2_q ? c_addr_d2_q : '0;
  assign sram_c_we_o   = we_d2_q;
  assign mac_valid_o   = valid_d1_q;
  assign mac_clear_o   = clear_d1_q;
  assign mac_last_o    = last_d1_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = (state_q == StDone);

endmodule

// File: tb/tb_gemm_loop_ctrl.sv
// Bench for gemm_loop_ctrl: cycle-exact comparison against a closed-form schedule model plus
// behavioural SRAMs and MAC whose C contents are compared with a golden matrix product.
module tb_gemm_loop_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i;
  logic [9:0] M_size_i, K_size_i, N_size_i;
  logic [9:0] sram_a_addr_o, sram_b_addr_o, sram_c_addr_o;
  logic       sram_c_we_o, mac_valid_o, mac_clear_o, mac_last_o, busy_o, done_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  a_mem [0:1023];
  logic [7:0]  b_mem [0:1023];
  logic [31:0] c_mem [0:1023];
  logic [7:0]  a_rd, b_rd;
  logic [31:0] acc;

  always #5 clk_i = ~clk_i;

  gemm_loop_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .M_size_i(M_size_i), .K_size_i(K_size_i), .N_size_i(N_size_i),
    .sram_a_addr_o(sram_a_addr_o), .sram_b_addr_o(sram_b_addr_o), .sram_c_addr_o(sram_c_addr_o),
    .sram_c_we_o(sram_c_we_o), .mac_valid_o(mac_valid_o), .mac_clear_o(mac_clear_o),
    .mac_last_o(mac_last_o), .busy_o(busy_o), .done_o(done_o)
  );

  // SRAMs with one cycle read latency and a MAC driven by the strobes.
  always @(posedge clk_i) begin
    a_rd <= a_mem[sram_a_addr_o];
    b_rd <= b_mem[sram_b_addr_o];
    if (mac_valid_o)
      acc <= mac_clear_o ? 32'(a_rd) * 32'(b_rd) : acc + 32'(a_rd) * 32'(b_rd);
    if (sram_c_we_o) c_mem[sram_c_addr_o] <= acc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run_job(input int m_sz, input int k_sz, input int n_sz,
                         input int restart_cyc, input int rst_cyc, input bit chk_mac);
    bit zero, aborted, chk_ab, v, w;
    int t_tot, done_c, t, mm, nn, kk, exp_a, exp_b, exp_c, activity;
    logic [31:0] sum;
    zero    = (m_sz == 0) || (k_sz == 0) || (n_sz == 0);
    t_tot   = zero ? 0 : m_sz * k_sz * n_sz;
    done_c  = zero ? 1 : t_tot + 3;
    aborted = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      a_mem[i] = 8'($urandom);
      b_mem[i] = 8'($urandom);
    end
    @(negedge clk_i);
    M_size_i = 10'(m_sz);
    K_size_i = 10'(k_sz);
    N_size_i = 10'(n_sz);
    start_i  = 1'b1;
    for (int c = 1; c <= done_c + 3; c++) begin
      @(negedge clk_i);
      start_i  = (c == restart_cyc);
      M_size_i = 10'($urandom);
      K_size_i = 10'($urandom);
      N_size_i = 10'($urandom);
      if (c == rst_cyc) begin
        rst_i = 1'b1;
        #1;
        check("rst_abort_outputs", 32'({sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
              mac_valid_o, mac_clear_o, mac_last_o, busy_o, done_o} != '0), 32'd0);
        aborted = 1'b1;
        break;
      end
      chk_ab = 1'b0; exp_a = 0; exp_b = 0;
      if (!zero && c <= t_tot) begin
        t  = c - 1;
        mm = t / (n_sz * k_sz); nn = (t / k_sz) % n_sz; kk = t % k_sz;
        exp_a = (mm * k_sz + kk) % 1024;
        exp_b = (kk * n_sz + nn) % 1024;
        chk_ab = 1'b1;
      end else if (c >= done_c) begin
        chk_ab = 1'b1;
      end
      if (chk_ab) begin
        check($sformatf("a_addr c%0d", c), 32'(sram_a_addr_o), 32'(exp_a));
        check($sformatf("b_addr c%0d", c), 32'(sram_b_addr_o), 32'(exp_b));
      end
      v = !zero && c >= 2 && c <= t_tot + 1;
      check($sformatf("mac_valid c%0d", c), 32'(mac_valid_o), 32'(v));
      if (v) begin
        t = c - 2;
        check($sformatf("mac_clear c%0d", c), 32'(mac_clear_o), 32'(t % k_sz == 0));
        check($sformatf("mac_last c%0d", c), 32'(mac_last_o), 32'(t % k_sz == k_sz - 1));
      end
      w = 1'b0;
      if (!zero && c >= 3 && c <= t_tot + 2) begin
        t = c - 3;
        w = (t % k_sz == k_sz - 1);
        exp_c = ((t / (n_sz * k_sz)) * n_sz + (t / k_sz) % n_sz) % 1024;
      end
      check($sformatf("c_we c%0d", c), 32'(sram_c_we_o), 32'(w));
      if (w) check($sformatf("c_addr c%0d", c), 32'(sram_c_addr_o), 32'(exp_c));
      check($sformatf("busy c%0d", c), 32'(busy_o), 32'(c <= done_c));
      check($sformatf("done c%0d", c), 32'(done_o), 32'(c == done_c));
    end
    start_i = 1'b0;
    if (aborted) begin
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      activity = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk_i);
        if (sram_c_we_o || busy_o || mac_valid_o) activity++;
      end
      check("no_activity_after_reset", 32'(activity), 32'd0);
    end else if (chk_mac && !zero) begin
      for (int i = 0; i < m_sz; i++)
        for (int j = 0; j < n_sz; j++) begin
          sum = 0;
          for (int q = 0; q < k_sz; q++)
            sum += 32'(a_mem[(i * k_sz + q) % 1024]) * 32'(b_mem[(q * n_sz + j) % 1024]);
          check($sformatf("c_data m%0d n%0d", i, j), c_mem[(i * n_sz + j) % 1024], sum);
        end
    end
  endtask

  initial begin
    int m_r, k_r, n_r, dc;
    rst_i    = 1'b1;
    start_i  = 1'b0;
    M_size_i = '0;
    K_size_i = '0;
    N_size_i = '0;
    repeat (2) @(negedge clk_i);
    check("reset_outputs", 32'({sram_a_addr_o, sram_b_addr_o, sram_c_addr_o, sram_c_we_o,
          mac_valid_o, mac_clear_o, mac_last_o, busy_o, done_o}), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    run_job(1, 1, 1, 0, 0, 1'b1);
    run_job(2, 3, 2, 0, 0, 1'b1);
    run_job(4, 0, 4, 0, 0, 1'b0);
    run_job(2, 3, 2, 5, 0, 1'b1);
    run_job(2, 3, 2, 0, 6, 1'b0);
    run_job(2, 3, 2, 0, 0, 1'b1);
    run_job(4, 8, 3, 0, 0, 1'b1);
    run_job(3, 1, 4, 0, 0, 1'b1);

    for (int r = 0; r < 10; r++) begin
      m_r = $urandom_range(0, 4);
      n_r = $urandom_range(1, 4);
      k_r = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6);
      dc  = (m_r == 0 || k_r == 0) ? 1 : m_r * k_r * n_r + 3;
      run_job(m_r, k_r, n_r, $urandom_range(1, dc), 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
